// File: rtl/input_capture_pkg.sv
// Shared definitions for the input capture block: edge-mode encodings,
// capture record width and the edge-mode match helper.
package input_capture_pkg;

    // edge_mode encodings
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_OFF  = 2'b11;

    // Record layout is {first, level, delta, value}
    localparam int COUNTER_SIZE_DEFAULT = 32;
    localparam int REC_W = 2 * COUNTER_SIZE_DEFAULT + 2;

    // Record width for an arbitrary counter width
    function automatic int rec_width(input int counter_size);
        return 2 * counter_size + 2;
    endfunction

    // True when the detected edge is one the current mode asks for
    function automatic logic edge_match(input logic [1:0] mode,
                                        input logic       rise,
                                        input logic       fall);
        logic hit;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            EDGE_OFF:  hit = 1'b0;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/input_capture_fifo.sv
// Synchronous record FIFO. The head record is read straight from storage
// flops, so it only changes on a pop. Push and pop in the same cycle are both
// accepted even when full.
module capture_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_pop_s;
    logic             do_push_s;

    assign do_pop_s  = pop & (count_r != {CW{1'b0}});
    assign do_push_s = push & ((count_r != DEPTH_C) | do_pop_s);

    assign head_data = mem_r[rd_ptr_r];
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;

    // Storage write and pointer advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/input_capture.sv
// Input capture: synchronises an asynchronous input, detects edges, stamps
// them with a free-running timebase, computes the delta to the previous
// capture and queues the records for a valid/ready consumer.
module input_capture
    import input_capture_pkg::*;
#(
    parameter int COUNTER_SIZE = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [1:0]                    edge_mode,
    input  logic                          capture_in,
    input  logic                          clear_overrun,
    input  logic                          cap_ready,
    output logic                          cap_valid,
    output logic [COUNTER_SIZE-1:0]       cap_value,
    output logic [COUNTER_SIZE-1:0]       cap_delta,
    output logic                          cap_level,
    output logic                          cap_first,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic [COUNTER_SIZE-1:0]       timebase,
    output logic                          tb_wrap
);
    localparam int RW = rec_width(COUNTER_SIZE);
    localparam int PW = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0] PRIMED_C = PW'(SYNC_STAGES + 1);
    localparam logic [COUNTER_SIZE-1:0] TB_MAX = {COUNTER_SIZE{1'b1}};

    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    sync_out_s;
    logic                    prev_r;
    logic [PW-1:0]           prime_cnt_r;
    logic                    primed_s;
    logic                    rise_r;
    logic                    fall_r;
    logic [COUNTER_SIZE-1:0] timebase_r;
    logic                    tb_wrap_r;
    logic                    enable_prev_r;
    logic                    first_pending_r;
    logic [COUNTER_SIZE-1:0] last_ts_r;
    logic                    event_s;
    logic                    first_s;
    logic [COUNTER_SIZE-1:0] delta_s;
    logic [RW-1:0]           stage_rec_r;
    logic                    push_r;
    logic                    pop_s;
    logic                    full_s;
    logic                    empty_s;
    logic [RW-1:0]           head_s;
    logic                    overrun_r;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    // Event comparisons start only once prev holds a genuine synchronised
    // sample, so a high input at reset release is not seen as an edge.
    assign primed_s   = (prime_cnt_r == PRIMED_C);

    // Synchroniser chain, previous-sample flop and registered edge flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r      <= {SYNC_STAGES{1'b0}};
            prev_r      <= 1'b0;
            prime_cnt_r <= {PW{1'b0}};
            rise_r      <= 1'b0;
            fall_r      <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], capture_in};
            prev_r <= sync_out_s;
            rise_r <= primed_s & sync_out_s & ~prev_r;
            fall_r <= primed_s & ~sync_out_s & prev_r;
            if (!primed_s) begin
                prime_cnt_r <= prime_cnt_r + PW'(1);
            end else begin
                prime_cnt_r <= prime_cnt_r;
            end
        end
    end

    // Free-running timebase and its wrap pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timebase_r <= {COUNTER_SIZE{1'b0}};
            tb_wrap_r  <= 1'b0;
        end else begin
            if (enable) begin
                timebase_r <= timebase_r + COUNTER_SIZE'(1);
            end else begin
                timebase_r <= timebase_r;
            end
            tb_wrap_r <= enable & (timebase_r == TB_MAX);
        end
    end

    // Event qualification, first-capture flag and delta
    always_comb begin
        event_s = 1'b0;
        first_s = first_pending_r | (enable & ~enable_prev_r);
        delta_s = timebase_r - last_ts_r;
        if (enable) begin
            event_s = edge_match(edge_mode, rise_r, fall_r);
        end else begin
            event_s = 1'b0;
        end
        if (first_s) begin
            delta_s = {COUNTER_SIZE{1'b0}};
        end else begin
            delta_s = timebase_r - last_ts_r;
        end
    end

    // Record staging; last_ts follows every event, including dropped ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_rec_r     <= {RW{1'b0}};
            push_r          <= 1'b0;
            last_ts_r       <= {COUNTER_SIZE{1'b0}};
            first_pending_r <= 1'b1;
            enable_prev_r   <= 1'b0;
        end else begin
            enable_prev_r <= enable;
            if (event_s) begin
                stage_rec_r     <= {first_s, rise_r, delta_s, timebase_r};
                push_r          <= 1'b1;
                last_ts_r       <= timebase_r;
                first_pending_r <= 1'b0;
            end else begin
                push_r <= 1'b0;
                if (enable & ~enable_prev_r) begin
                    first_pending_r <= 1'b1;
                end else begin
                    first_pending_r <= first_pending_r;
                end
            end
        end
    end

    assign pop_s = ~empty_s & cap_ready;

    // Sticky overrun; a drop in the same cycle beats a clear request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_r <= 1'b0;
        end else begin
            if (push_r & full_s & ~pop_s) begin
                overrun_r <= 1'b1;
            end else if (clear_overrun) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    capture_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_r),
        .push_data (stage_rec_r),
        .pop       (pop_s),
        .head_data (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (fifo_count)
    );

    assign cap_valid = ~empty_s;
    assign {cap_first, cap_level, cap_delta, cap_value} = head_s;
    assign overrun   = overrun_r;
    assign timebase  = timebase_r;
    assign tb_wrap   = tb_wrap_r;

endmodule

// File: tb/tb_input_capture.sv
// Scoreboard bench for input_capture. A behavioural model turns input
// transitions into expected records; a separate monitor compares the head
// record whenever the DUT presents one.
module tb_input_capture;
    localparam int N = 12;
    localparam int D = 4;
    localparam int S = 2;

    typedef struct packed {
        logic         first;
        logic         level;
        logic [N-1:0] delta;
        logic [N-1:0] value;
    } rec_t;

    typedef struct {
        int det;
        bit lvl;
    } pend_t;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic [1:0]   edge_mode;
    logic         capture_in;
    logic         clear_overrun;
    logic         cap_ready;
    logic         cap_valid;
    logic [N-1:0] cap_value;
    logic [N-1:0] cap_delta;
    logic         cap_level;
    logic         cap_first;
    logic [2:0]   fifo_count;
    logic         overrun;
    logic [N-1:0] timebase;
    logic         tb_wrap;

    input_capture #(.COUNTER_SIZE(N), .FIFO_DEPTH(D), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .edge_mode(edge_mode),
        .capture_in(capture_in), .clear_overrun(clear_overrun), .cap_ready(cap_ready),
        .cap_valid(cap_valid), .cap_value(cap_value), .cap_delta(cap_delta),
        .cap_level(cap_level), .cap_first(cap_first), .fifo_count(fifo_count),
        .overrun(overrun), .timebase(timebase), .tb_wrap(tb_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [N-1:0] tbm;
    bit           wrap_m;
    int           mcount;
    bit           ovr_m;
    bit           cin_prev;
    bit           en_prev;
    bit           first_flag;
    logic [N-1:0] last_ts;
    bit           staged;
    rec_t         staged_rec;
    int           cyc;
    pend_t        pend[$];
    rec_t         exp_q[$];

    function automatic bit mode_ok(input logic [1:0] mode, input bit lvl);
        if (mode == 2'b10) return 1'b1;
        if (lvl) return mode == 2'b00;
        return mode == 2'b01;
    endfunction

    // Model: evaluated mid-cycle, when this cycle's inputs are stable
    always @(negedge clk) begin : model
        bit    pop;
        pend_t p;
        rec_t  r;
        if (!reset_n) begin
            tbm = '0; wrap_m = 0; mcount = 0; ovr_m = 0; cin_prev = capture_in;
            en_prev = 0; first_flag = 1; last_ts = '0; staged = 0; cyc = 0;
            pend.delete(); exp_q.delete();
        end else begin
            check("timebase", 64'(timebase), 64'(tbm));
            check("tb_wrap", 64'(tb_wrap), 64'(wrap_m));
            check("fifo_count", 64'(fifo_count), 64'(mcount));
            check("cap_valid", 64'(cap_valid), 64'(mcount > 0));
            check("overrun", 64'(overrun), 64'(ovr_m));
            pop = (mcount > 0) && cap_ready;
            if (staged) begin
                if (mcount < D || pop) begin
                    exp_q.push_back(staged_rec);
                    mcount++;
                end else begin
                    ovr_m = 1;
                end
            end
            if (!(staged && !(mcount <= D && (mcount < D || pop))) && clear_overrun) ovr_m = 0;
            if (pop) mcount--;
            staged = 0;
            if (capture_in !== cin_prev) pend.push_back('{cyc + S + 1, capture_in});
            cin_prev = capture_in;
            if (enable && !en_prev) first_flag = 1;
            while (pend.size() > 0 && pend[0].det <= cyc) begin
                p = pend.pop_front();
                if (enable && mode_ok(edge_mode, p.lvl)) begin
                    r.first = first_flag;
                    r.level = p.lvl;
                    r.delta = first_flag ? '0 : tbm - last_ts;
                    r.value = tbm;
                    last_ts = tbm;
                    first_flag = 0;
                    staged = 1;
                    staged_rec = r;
                end
            end
            en_prev = enable;
            wrap_m = enable && (tbm == {N{1'b1}});
            if (enable) tbm = tbm + 1'b1;
            cyc++;
        end
    end

    // Monitor: every presented record must equal the expected head
    int   popped = 0;
    rec_t last_pop;
    int   wraps_seen = 0;
    always @(negedge clk) begin : monitor
        if (reset_n && tb_wrap) wraps_seen++;
        if (reset_n && cap_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_record actual=%0h required=none",
                         {cap_first, cap_level, cap_delta, cap_value});
            end else begin
                check("record", 64'({cap_first, cap_level, cap_delta, cap_value}), 64'(exp_q[0]));
                if (cap_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                    last_pop = {cap_first, cap_level, cap_delta, cap_value};
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggles(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            capture_in = ~capture_in;
            tick(gap);
        end
    endtask

    initial begin : stim
        int base;
        int waited;
        reset_n = 0; enable = 0; edge_mode = 2'b00; capture_in = 1;
        clear_overrun = 0; cap_ready = 0;
        tick(3);
        check("rst_cap_valid", 64'(cap_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_timebase", 64'(timebase), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset_n = 1; enable = 1;
        tick(10);

        // 1: high input at release gives nothing; 1->0->1 gives one first record
        check("t1_no_spurious", 64'(fifo_count), 64'd0);
        capture_in = 0; tick(5);
        capture_in = 1; tick(8);
        cap_ready = 1; tick(4);
        check("t1_records", 64'(popped), 64'd1);
        check("t1_first_level_delta", 64'({last_pop.first, last_pop.level, last_pop.delta}),
              64'({1'b1, 1'b1, 12'h000}));

        // 2: rising edges 100 cycles apart
        capture_in = 0; tick(20);
        capture_in = 1; tick(50);
        capture_in = 0; tick(50);
        capture_in = 1; tick(10);
        check("t2_delta", 64'(last_pop.delta), 64'd100);

        // 3: both edges, consumer stalled, six edges into a four-deep FIFO
        cap_ready = 0; edge_mode = 2'b10;
        base = popped;
        toggles(6, 4);
        tick(10);
        check("t3_count", 64'(fifo_count), 64'd4);
        check("t3_overrun", 64'(overrun), 64'd1);
        cap_ready = 1; tick(6); cap_ready = 0;
        check("t3_drained", 64'(popped - base), 64'd4);
        clear_overrun = 1; tick(1); clear_overrun = 0; tick(1);
        check("t3_cleared", 64'(overrun), 64'd0);

        // 4: capture across the timebase wrap
        edge_mode = 2'b00; cap_ready = 1;
        capture_in = 0;
        waited = 0;
        while (tbm != 12'hFF0 - 12'(S + 1) && waited < 5000) begin
            tick(1); waited++;
        end
        check("t4_wait_bound", 64'(waited < 5000), 64'd1);
        wraps_seen = 0;
        capture_in = 1; tick(16);
        capture_in = 0; tick(16);
        capture_in = 1; tick(10);
        check("t4_delta", 64'(last_pop.delta), 64'h020);
        check("t4_value", 64'(last_pop.value), 64'h010);
        check("t4_wraps", 64'(wraps_seen), 64'd1);

        // 5: full FIFO with a same-cycle pop at the push
        cap_ready = 0; edge_mode = 2'b10;
        toggles(4, 4);
        tick(6);
        check("t5_full", 64'(fifo_count), 64'd4);
        capture_in = ~capture_in;
        tick(S + 2);
        cap_ready = 1; tick(1); cap_ready = 0;
        tick(3);
        check("t5_count", 64'(fifo_count), 64'd4);
        check("t5_no_overrun", 64'(overrun), 64'd0);
        tick(5);
        cap_ready = 1; tick(8);

        // 6: asynchronous reset with records queued, then enable re-arm
        cap_ready = 0;
        toggles(3, 4);
        tick(8);
        @(negedge clk); #2;
        reset_n = 0; #1;
        check("t6_valid", 64'(cap_valid), 64'd0);
        check("t6_count", 64'(fifo_count), 64'd0);
        check("t6_timebase", 64'(timebase), 64'd0);
        tick(2);
        reset_n = 1; edge_mode = 2'b00; cap_ready = 1;
        tick(10);
        capture_in = 0; tick(6); capture_in = 1; tick(8);
        check("t6_first_after_reset", 64'(last_pop.first), 64'd1);
        capture_in = 0; tick(6); capture_in = 1; tick(8);
        check("t6_not_first", 64'(last_pop.first), 64'd0);
        enable = 0; tick(5); enable = 1; tick(2);
        capture_in = 0; tick(6); capture_in = 1; tick(8);
        check("t6_first_after_enable", 64'(last_pop.first), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(5) == 0) capture_in = ~capture_in;
            cap_ready = ($urandom_range(1) == 1);
            if ($urandom_range(60) == 0) edge_mode = 2'($urandom_range(3));
            if ($urandom_range(120) == 0) enable = ~enable;
            if (!enable && $urandom_range(10) == 0) enable = 1;
            clear_overrun = ($urandom_range(30) == 0);
            tick(1);
        end
        clear_overrun = 0; enable = 1; cap_ready = 1;
        tick(20);
        check("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
